// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared defaults and index-width helper for the round-robin mux
package mux_pkg;

    localparam int MUX_DEFAULT_NUM_CH = 4;
    localparam int MUX_DEFAULT_DATA_W = 8;

    function automatic int ch_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - circular-priority arbiter owning the round-robin pointer
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = MUX_DEFAULT_NUM_CH,
    localparam int CH_W = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              advance_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CH_W-1:0]   grant_idx_o
);

    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] ptr_d;
    logic            found;

    // Search starts at ptr_q; the index is folded back explicitly so NUM_CH need not be a power of two.
    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = CH_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (grant_idx_o == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_o + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_rr.sv
// rtl/mux_rr.sv - N:1 round-robin mux with ready/pop handshake; channel_out under MUX_RR_CHAN_ID_EN
module mux_rr
    import mux_pkg::*;
#(
    parameter int NUM_CH = MUX_DEFAULT_NUM_CH,
    parameter int DATA_W = MUX_DEFAULT_DATA_W,
    localparam int CH_W = ch_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        valid_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic                     ready_in,
    output logic [NUM_CH-1:0]        pop_out,
    output logic [DATA_W-1:0]        data_out,
`ifdef MUX_RR_CHAN_ID_EN
    output logic [CH_W-1:0]          channel_out,
`endif
    output logic                     valid_out
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              load;
    logic              any_req;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic [DATA_W-1:0] data_sel;

    assign load    = !valid_q || ready_in;
    assign any_req = |valid_in;

    rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_i      (valid_in),
        .advance_i  (load && any_req),
        .grant_o    (grant),
        .grant_idx_o(grant_idx)
    );

    assign pop_out  = (reset || !load) ? '0 : grant;
    assign data_sel = data_in[int'(grant_idx)*DATA_W +: DATA_W];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = any_req;
            data_d  = any_req ? data_sel : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

`ifdef MUX_RR_CHAN_ID_EN
    logic [CH_W-1:0] chan_q, chan_d;

    // An idle load keeps the last source index rather than clearing it.
    always_comb begin
        chan_d = chan_q;
        if (load && any_req) begin
            chan_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chan_q <= '0;
        end else begin
            chan_q <= chan_d;
        end
    end

    assign channel_out = chan_q;
`endif

endmodule

// File: tb/tb_mux_rr.sv
// tb/tb_mux_rr.sv - self-checking bench for mux_rr (4-channel and 3-channel instances)
module tb_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vin4;
    logic [31:0] din4;
    logic        rdy4;
    logic [3:0]  pop4;
    logic [7:0]  dout4;
    logic        vout4;
    logic [2:0]  vin3;
    logic [23:0] din3;
    logic        rdy3;
    logic [2:0]  pop3;
    logic [7:0]  dout3;
    logic        vout3;
`ifdef MUX_RR_CHAN_ID_EN
    logic [1:0]  ch4;
    logic [1:0]  ch3;
`endif

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    mux_rr #(.NUM_CH(4), .DATA_W(8)) dut4 (
        .clk(clk), .reset(rst), .valid_in(vin4), .data_in(din4), .ready_in(rdy4),
        .pop_out(pop4), .data_out(dout4),
`ifdef MUX_RR_CHAN_ID_EN
        .channel_out(ch4),
`endif
        .valid_out(vout4)
    );

    mux_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
        .clk(clk), .reset(rst), .valid_in(vin3), .data_in(din3), .ready_in(rdy3),
        .pop_out(pop3), .data_out(dout3),
`ifdef MUX_RR_CHAN_ID_EN
        .channel_out(ch3),
`endif
        .valid_out(vout3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: grant is the first requesting channel at or after ptr, going around the ring.
    function automatic int mgrant(input int n, input int ptr, input logic [3:0] v,
                                  input logic out_valid, input logic rdy, input logic r);
        if (r || (out_valid && !rdy)) return -1;
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    int         m4_ptr = 0, m3_ptr = 0, m4_ch = 0, m3_ch = 0;
    logic       m4_v = 1'b0, m3_v = 1'b0;
    logic [7:0] m4_d = 8'h00, m3_d = 8'h00;
    int         g4, g3;

    always_comb g4 = mgrant(4, m4_ptr, vin4, m4_v, rdy4, rst);
    always_comb g3 = mgrant(3, m3_ptr, {1'b0, vin3}, m3_v, rdy3, rst);

    always @(posedge clk) begin
        if (rst) begin
            m4_v <= 1'b0; m4_d <= 8'h00; m4_ptr <= 0; m4_ch <= 0;
            m3_v <= 1'b0; m3_d <= 8'h00; m3_ptr <= 0; m3_ch <= 0;
        end else begin
            if (!m4_v || rdy4) begin
                if (g4 >= 0) begin
                    m4_v <= 1'b1; m4_d <= din4[g4*8 +: 8]; m4_ch <= g4; m4_ptr <= (g4 + 1) % 4;
                end else begin
                    m4_v <= 1'b0; m4_d <= 8'h00;
                end
            end
            if (!m3_v || rdy3) begin
                if (g3 >= 0) begin
                    m3_v <= 1'b1; m3_d <= din3[g3*8 +: 8]; m3_ch <= g3; m3_ptr <= (g3 + 1) % 3;
                end else begin
                    m3_v <= 1'b0; m3_d <= 8'h00;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_pop4", 32'(pop4), (g4 < 0) ? 32'd0 : (32'd1 << g4));
            chk("model_vout4", 32'(vout4), 32'(m4_v));
            chk("model_dout4", 32'(dout4), 32'(m4_d));
            chk("model_pop3", 32'(pop3), (g3 < 0) ? 32'd0 : (32'd1 << g3));
            chk("model_vout3", 32'(vout3), 32'(m3_v));
            chk("model_dout3", 32'(dout3), 32'(m3_d));
`ifdef MUX_RR_CHAN_ID_EN
            chk("model_ch4", 32'(ch4), 32'(m4_ch));
            chk("model_ch3", 32'(ch3), 32'(m3_ch));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst  = 1'b1;
        vin4 = 4'hF;
        din4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        rdy4 = 1'b1;
        vin3 = 3'b000;
        din3 = {8'hC2, 8'hC1, 8'hC0};
        rdy3 = 1'b1;

        // Reset held two cycles with every channel requesting
        cyc();
        check_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_pop", 32'(pop4), 32'd0);
            chk("rst_vout", 32'(vout4), 32'd0);
            chk("rst_dout", 32'(dout4), 32'd0);
            if (k == 0) cyc();
        end
        rst = 1'b0;
        #1;
        chk("first_pop", 32'(pop4), 32'b0001);

        // All four valid: A0,A1,A2,A3,A0
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rr_dout", 32'(dout4), 32'hA0 + 32'(k % 4));
            chk("rr_vout", 32'(vout4), 32'd1);
`ifdef MUX_RR_CHAN_ID_EN
            chk("rr_ch", 32'(ch4), 32'(k % 4));
`endif
            #1;
            chk("rr_pop", 32'(pop4), 32'd1 << ((k + 1) % 4));
        end

        // Sparse 1010 from ptr 0 then only channel 2
        rst = 1'b1;
        cyc();
        rst  = 1'b0;
        vin4 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("sparse_pop", 32'(pop4), (k % 2 == 1) ? 32'b1000 : 32'b0010);
            cyc();
            chk("sparse_dout", 32'(dout4), (k % 2 == 1) ? 32'hA3 : 32'hA1);
        end
        vin4 = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ch2_pop", 32'(pop4), 32'b0100);
            cyc();
            chk("ch2_dout", 32'(dout4), 32'hA2);
        end

        // Backpressure: 11 then 3 stalled cycles then 22,33
        vin4       = 4'b0001;
        din4[7:0]  = 8'h11;
        #1;
        chk("bp_pop_11", 32'(pop4), 32'b0001);
        cyc();
        chk("bp_dout_11", 32'(dout4), 32'h11);
        din4[7:0] = 8'h22;
        rdy4      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_pop", 32'(pop4), 32'd0);
            cyc();
            chk("stall_dout", 32'(dout4), 32'h11);
            chk("stall_vout", 32'(vout4), 32'd1);
        end
        rdy4 = 1'b1;
        #1;
        chk("bp_pop_22", 32'(pop4), 32'b0001);
        cyc();
        chk("bp_dout_22", 32'(dout4), 32'h22);
        din4[7:0] = 8'h33;
        #1;
        chk("bp_pop_33", 32'(pop4), 32'b0001);
        cyc();
        chk("bp_dout_33", 32'(dout4), 32'h33);

        // Idle with ready high
        vin4 = 4'b0000;
        #1;
        chk("idle_pop", 32'(pop4), 32'd0);
        cyc();
        chk("idle_vout", 32'(vout4), 32'd0);
        chk("idle_dout", 32'(dout4), 32'd0);

        // Reset during a stall discards the word and the pointer
        vin4 = 4'b0010;
        rdy4 = 1'b0;
        cyc();
        chk("pre_rst_dout", 32'(dout4), 32'hA1);
        #1;
        chk("pre_rst_pop", 32'(pop4), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_stall_pop", 32'(pop4), 32'd0);
        cyc();
        chk("rst_stall_vout", 32'(vout4), 32'd0);
        rst  = 1'b0;
        vin4 = 4'hF;
        rdy4 = 1'b1;
        #1;
        chk("post_rst_pop", 32'(pop4), 32'b0001);
        cyc();
        chk("post_rst_dout", 32'(dout4), 32'h33);

        // Three channels: 0,1,2,0 with explicit wrap
        vin3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("nc3_pop", 32'(pop3), 32'd1 << (k % 3));
            cyc();
            chk("nc3_dout", 32'(dout3), 32'hC0 + 32'(k % 3));
`ifdef MUX_RR_CHAN_ID_EN
            chk("nc3_ch", 32'(ch3), 32'(k % 3));
`endif
        end

        // Mixed request/ready patterns checked by the model only
        for (int i = 0; i < 24; i++) begin
            vin4 = 4'((i * 7 + 3) % 16);
            rdy4 = (i % 3) != 1;
            vin3 = 3'((i * 5) % 8);
            rdy3 = (i % 4) != 2;
            din4 = {8'(i + 8'h40), 8'(i + 8'h30), 8'(i + 8'h20), 8'(i + 8'h10)};
            din3 = {8'(i + 8'h70), 8'(i + 8'h60), 8'(i + 8'h50)};
            cyc();
        end

        @(posedge clk);
        #2;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
